lsu_subword: RTL and testbench
==============================

Name: lsu_subword

Overview:
- Load/store unit between the CPU execute stage and the word-addressed data memory (`d_memory`).
- Accepts byte, halfword and word requests with a valid/ready handshake.
- Performs the address range check and the misalignment check.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: implemented as read-modify-write, because the memory supports only full-word writes.
- Drives the memory's mem_read/mem_write/addr/wdata pins and consumes its 1-cycle-latency rdata.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- BASE_ADDR, 32'h0001_0000, first byte address of data memory.
- MEM_DEPTH, 1024, memory depth in words; valid range is BASE_ADDR to BASE_ADDR+4*MEM_DEPTH-1.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts the response
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or out of range
- mem_read  out  1  memory read strobe, registered
- mem_write  out  1  memory write strobe, registered
- mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0), registered
- mem_wdata  out  DATA_WIDTH  full-word write data, registered
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after the mem_read edge

Behaviour:
- Reset: state IDLE; req_ready=1; every other output is 0.
  - Asynchronous reset mid-operation abandons the transaction.
  - A mem_write not yet sampled by memory is never performed, so the memory word is unchanged.
- Accept: at edge N when IDLE && req_valid. All request fields are latched; off = req_addr[1:0].
- Error (no memory access, mem_* stay 0): any of the following.
  - req_size == 11.
  - Misaligned: half with off[0] = 1, or word with off != 0.
  - Address out of range.
  - Error response: at edge N the state becomes RESP with resp_err=1 and resp_rdata=0, so the response is visible 1 cycle after accept.
- Load:
  - Edge N: mem_read=1, mem_addr set, state RD.
  - Edge N+1: mem_read=0, state WAIT.
  - Edge N+2: lane extracted from mem_rdata, resp_valid=1, state RESP. Latency is 2 cycles.
- Word store:
  - Edge N: mem_write=1, mem_wdata=req_wdata, state WR.
  - Edge N+1: mem_write=0, resp_valid=1. Latency is 1 cycle.
- Sub-word store:
  - Edge N: mem_read=1, state RMW_RD.
  - Edge N+1: mem_read=0, state RMW_WAIT.
  - Edge N+2: merge lane into mem_rdata, mem_write=1 with merged word, state WR.
  - Edge N+3: mem_write=0, resp_valid=1. Latency is 3 cycles.
- Lanes are little-endian.
  - Byte lane = bits [8*off+7 : 8*off].
  - Half lane = bits [8*off+15 : 8*off], off ∈ {0, 2}.
  - Stores take the low byte or half of req_wdata.
- RESP state:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake edge: state IDLE, resp_valid=0, req_ready=1 in the next cycle.
  - No request is accepted in the same cycle as the response handshake.
- mem_read and mem_write are never high simultaneously. Each is a single-cycle pulse per access.
- States: IDLE, RD, WAIT, RMW_RD, RMW_WAIT, WR, RESP.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum lsu_state_t.
- Sub-module lsu_lane_align (combinational) has two functions:
  - load extract + sign/zero extend.
  - store merge.
- The FSM and registers live in lsu_subword.
- All tests use `d_memory` with default parameters, zero-initialised, as the memory model.

Test Plan:
1. Word store 0xDEADBEEF @0x0001_0004, then word load @0x0001_0004.
   - Store: one mem_write pulse, resp at N+1.
   - Load: resp_rdata=0xDEADBEEF, resp_err=0, resp at N+2.
2. Byte store 0x000000A5 @0x0001_0005 after test 1.
   - Exactly one mem_read, then one mem_write with mem_wdata=0xDEADA5EF, resp at N+3.
   - Signed byte load @0x0001_0005 → 0xFFFFFFA5.
   - Unsigned byte load @0x0001_0005 → 0x000000A5.
   - Signed half load @0x0001_0006 → 0xFFFFDEAD.
3. Errors, each with no mem_read/mem_write pulse and resp_err=1 one cycle after accept:
   - Half load @0x0001_0003.
   - Word store @0x0001_0002.
   - req_size=11.
4. Range boundaries:
   - Word load @0x0001_0FFC → err=0.
   - @0x0001_1000 → err=1.
   - @0x0000_FFFC → err=1.
5. Back-pressure: hold resp_ready=0 for 3 cycles after resp_valid.
   - resp_valid, resp_rdata, resp_err stay stable; req_ready=0.
   - A pending req_valid is not accepted until the cycle after the handshake.
6. Reset mid-RMW: assert reset_n=0 while state is RMW_WAIT during a byte store to 0x0001_0008.
   - All outputs go 0 immediately; mem_write never pulses.
   - Word @0x0001_0008 reads back 0 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: request sizes and FSM state codes.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE     = 3'd0;
  localparam lsu_state_t ST_RD       = 3'd1;
  localparam lsu_state_t ST_WAIT     = 3'd2;
  localparam lsu_state_t ST_RMW_RD   = 3'd3;
  localparam lsu_state_t ST_RMW_WAIT = 3'd4;
  localparam lsu_state_t ST_WR       = 3'd5;
  localparam lsu_state_t ST_RESP     = 3'd6;

endpackage

// File: rtl/lsu_subword_if.sv
// Core request/response handshake plus the word-wide data memory pins.
interface lsu_subword_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge into a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: load_o = unsigned_i ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_o = unsigned_i ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_o = rdata_i;
    if (size_i == SZ_BYTE) begin
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else begin
      merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
    end
  end
endmodule

// File: rtl/lsu_subword.sv
// Load/store unit: range/alignment checks, sub-word loads, and read-modify-write
// sub-word stores against a word-only memory with 1-cycle read latency.
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned           MEM_DEPTH  = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  lsu_subword_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(4 * MEM_DEPTH);

  lsu_state_t            state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  uns_q, uns_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_WIDTH-1:0] rel_addr;
  logic                  req_err;
  logic [31:0]           load_data, merge_data;

  // Subtracting the base wraps addresses below it to huge values, so one compare covers both ends.
  assign rel_addr = bus.req_addr - BASE_ADDR;
  assign req_err  = (bus.req_size == 2'b11) || (rel_addr >= MemBytes) ||
                    ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                    ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  lsu_lane_align u_lane_align (
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .rdata_i    (bus.mem_rdata),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    off_d        = off_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          size_d  = bus.req_size;
          off_d   = bus.req_addr[1:0];
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata[15:0];
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = ST_RESP;
          end else begin
            mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (!bus.req_we) begin
              mem_read_d = 1'b1;
              state_d    = ST_RD;
            end else if (bus.req_size == SZ_WORD) begin
              mem_write_d = 1'b1;
              mem_wdata_d = bus.req_wdata;
              state_d     = ST_WR;
            end else begin
              mem_read_d = 1'b1;
              state_d    = ST_RMW_RD;
            end
          end
        end
      end
      ST_RD:     state_d = ST_WAIT;
      ST_WAIT: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_data;
        state_d      = ST_RESP;
      end
      ST_RMW_RD: state_d = ST_RMW_WAIT;
      ST_RMW_WAIT: begin
        mem_write_d = 1'b1;
        mem_wdata_d = merge_data;
        state_d     = ST_WR;
      end
      ST_WR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          state_d      = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      size_q       <= '0;
      off_q        <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: directed scenarios plus random traffic, checked every cycle
// against a transaction-level timeline model and a word-array memory.
module tb_lsu_subword;
  localparam logic [31:0] Base = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  lsu_subword_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_subword u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h required %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-addressed data memory with one-cycle read latency.
  logic [31:0] dmem [1024] = '{default: '0};
  logic [31:0] ref_mem [1024] = '{default: '0};
  logic [31:0] mem_rdata_q = '0;
  function automatic logic [9:0] widx(input logic [31:0] a);
    return 10'((a - Base) >> 2);
  endfunction
  always @(posedge clk) begin
    if (bus.mem_write) dmem[widx(bus.mem_addr)] <= bus.mem_wdata;
    if (bus.mem_read) mem_rdata_q <= dmem[widx(bus.mem_addr)];
  end
  assign bus.mem_rdata = mem_rdata_q;

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
    longint unsigned nb, lim, v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lim = 64'd1 << (8 * nb);
    v = (longint'(word) >> (8 * off)) % lim;
    if (!uns && v >= lim / 2) v = v + (64'h1_0000_0000 - lim);
    return 32'(v);
  endfunction

  function automatic logic [31:0] merge_model(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
    longint unsigned lim, mask;
    lim = (sz == 2'd0) ? 64'h100 : 64'h1_0000;
    mask = (lim - 1) << (8 * off);
    return 32'((longint'(word) & ~mask) | ((longint'(wd) % lim) << (8 * off)));
  endfunction

  // Timeline model: age counts edges since the accepting edge (1 = cycle after accept).
  logic        m_busy = 1'b0;
  int          m_age, m_vis, m_wr_age;
  logic        m_has_rd, m_has_wr, m_err, m_store;
  logic [31:0] m_rdata, m_wword, m_addr;
  logic [9:0]  m_idx;
  int          m_acc = 0;
  int          mon_rd = 0, mon_wr = 0;
  logic [31:0] mon_last_wdata = '0;

  task automatic model_accept();
    logic [31:0] a;
    logic [1:0]  sz, off;
    a = bus.req_addr;
    sz = bus.req_size;
    off = a[1:0];
    m_err = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0) ||
            (a < Base) || (a >= Base + 32'd4096);
    m_idx = widx(a);
    m_addr = {a[31:2], 2'b00};
    m_has_rd = 1'b0;
    m_has_wr = 1'b0;
    m_wr_age = 0;
    m_rdata = '0;
    m_wword = '0;
    m_store = bus.req_we && !m_err;
    if (m_err) m_vis = 1;
    else if (!bus.req_we) begin
      m_vis = 3;
      m_has_rd = 1'b1;
      m_rdata = load_model(ref_mem[m_idx], sz, off, bus.req_unsigned);
    end else if (sz == 2'd2) begin
      m_vis = 2;
      m_has_wr = 1'b1;
      m_wr_age = 1;
      m_wword = bus.req_wdata;
    end else begin
      m_vis = 4;
      m_has_rd = 1'b1;
      m_has_wr = 1'b1;
      m_wr_age = 3;
      m_wword = merge_model(ref_mem[m_idx], sz, off, bus.req_wdata);
    end
    m_busy = 1'b1;
    m_age = 1;
    m_acc++;
  endtask

  always @(negedge clk) begin
    logic exp_rv;
    if (!reset_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      m_busy = 1'b0;
    end else begin
      exp_rv = m_busy && (m_age >= m_vis);
      chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("resp_rdata", bus.resp_rdata, m_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(m_err));
      end
      chk("mem_read", 32'(bus.mem_read), 32'(m_busy && m_has_rd && m_age == 1));
      chk("mem_write", 32'(bus.mem_write), 32'(m_busy && m_has_wr && m_age == m_wr_age));
      if (bus.mem_read) begin
        mon_rd++;
        chk("rd_addr", bus.mem_addr, m_addr);
      end
      if (bus.mem_write) begin
        mon_wr++;
        mon_last_wdata = bus.mem_wdata;
        chk("wr_addr", bus.mem_addr, m_addr);
        chk("wr_data", bus.mem_wdata, m_wword);
      end
      if (m_busy) begin
        if (exp_rv && bus.resp_ready) begin
          if (m_store) ref_mem[m_idx] = m_wword;
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (bus.req_valid) begin
        model_accept();
      end
    end
  end

  int acc0;

  task automatic present(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    acc0 = m_acc;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_acc == acc0 && n < 20);
    if (m_acc == acc0) chk("accept_timeout", 32'(n), 32'd0);
    bus.req_valid = 1'b0;
    mon_rd = 0;
    mon_wr = 0;
  endtask

  // Called just after the accepting edge; lat = edges after accept until resp_valid appears.
  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.resp_valid) chk("resp_timeout", 32'(lat), 32'd0);
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  task automatic release_resp(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int hold,
                      output int lat, output logic [31:0] rd, output logic er);
    present(we, sz, uns, a, wd);
    wait_accept();
    wait_resp(lat, rd, er);
    release_resp(hold);
  endtask

  initial begin
    int lat;
    logic [31:0] rd, a;
    logic er;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("pin_signed_byte", load_model(32'hDEADA5EF, 2'd0, 2'd1, 1'b0), 32'hFFFF_FFA5);
    chk("pin_signed_half", load_model(32'hDEADA5EF, 2'd1, 2'd2, 1'b0), 32'hFFFF_DEAD);
    chk("pin_merge_byte", merge_model(32'hDEADBEEF, 2'd0, 2'd1, 32'h0000_00A5), 32'hDEAD_A5EF);

    xact(1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'hDEADBEEF, 0, lat, rd, er);
    chk("t1_store_lat", 32'(lat), 32'd1);
    chk("t1_store_wr", 32'(mon_wr), 32'd1);
    xact(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, 0, lat, rd, er);
    chk("t1_load_data", rd, 32'hDEADBEEF);
    chk("t1_load_err", 32'(er), 32'd0);
    chk("t1_load_lat", 32'(lat), 32'd2);

    xact(1'b1, 2'd0, 1'b0, 32'h0001_0005, 32'h0000_00A5, 0, lat, rd, er);
    chk("t2_rmw_lat", 32'(lat), 32'd3);
    chk("t2_rmw_rd", 32'(mon_rd), 32'd1);
    chk("t2_rmw_wr", 32'(mon_wr), 32'd1);
    chk("t2_rmw_word", mon_last_wdata, 32'hDEADA5EF);
    xact(1'b0, 2'd0, 1'b0, 32'h0001_0005, 32'h0, 0, lat, rd, er);
    chk("t2_lb", rd, 32'hFFFF_FFA5);
    xact(1'b0, 2'd0, 1'b1, 32'h0001_0005, 32'h0, 0, lat, rd, er);
    chk("t2_lbu", rd, 32'h0000_00A5);
    xact(1'b0, 2'd1, 1'b0, 32'h0001_0006, 32'h0, 0, lat, rd, er);
    chk("t2_lh", rd, 32'hFFFF_DEAD);

    xact(1'b0, 2'd1, 1'b0, 32'h0001_0003, 32'h0, 0, lat, rd, er);
    chk("t3_half_mis_err", 32'(er), 32'd1);
    chk("t3_half_mis_lat", 32'(lat), 32'd0);
    chk("t3_half_mis_mem", 32'(mon_rd + mon_wr), 32'd0);
    xact(1'b1, 2'd2, 1'b0, 32'h0001_0002, 32'h1234_5678, 0, lat, rd, er);
    chk("t3_word_mis_err", 32'(er), 32'd1);
    chk("t3_word_mis_mem", 32'(mon_rd + mon_wr), 32'd0);
    xact(1'b0, 2'd3, 1'b0, 32'h0001_0000, 32'h0, 0, lat, rd, er);
    chk("t3_size_err", 32'(er), 32'd1);
    chk("t3_size_rdata", rd, 32'd0);

    xact(1'b0, 2'd2, 1'b0, 32'h0001_0FFC, 32'h0, 0, lat, rd, er);
    chk("t4_top_ok", 32'(er), 32'd0);
    xact(1'b0, 2'd2, 1'b0, 32'h0001_1000, 32'h0, 0, lat, rd, er);
    chk("t4_above_err", 32'(er), 32'd1);
    xact(1'b0, 2'd2, 1'b0, 32'h0000_FFFC, 32'h0, 0, lat, rd, er);
    chk("t4_below_err", 32'(er), 32'd1);

    // Back-pressure with a second request already waiting behind the response.
    present(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0);
    wait_accept();
    present(1'b0, 2'd0, 1'b1, 32'h0001_0005, 32'h0);
    wait_resp(lat, rd, er);
    chk("t5_first_data", rd, 32'hDEADA5EF);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t5_hold_data", bus.resp_rdata, 32'hDEADA5EF);
      chk("t5_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("t5_no_accept", 32'(m_acc), 32'(acc0));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("t5_idle_after_hs", 32'(bus.req_ready), 32'd1);
    wait_accept();
    wait_resp(lat, rd, er);
    chk("t5_second_data", rd, 32'h0000_00A5);
    release_resp(0);

    // Reset while the byte store sits between its read and its write.
    present(1'b1, 2'd0, 1'b0, 32'h0001_0008, 32'h0000_0077);
    wait_accept();
    for (int i = 0; i < 5 && !(m_busy && m_age == 2); i++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t6_no_write", 32'(mon_wr), 32'd0);
    xact(1'b0, 2'd2, 1'b0, 32'h0001_0008, 32'h0, 0, lat, rd, er);
    chk("t6_word_zero", rd, 32'd0);

    for (int t = 0; t < 200; t++) begin
      int r;
      logic [1:0] sz;
      r = $urandom_range(0, 15);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      case ($urandom_range(0, 11))
        0: a = Base - 32'd4;
        1: a = Base - 32'd1;
        2: a = Base + 32'd4092 + 32'($urandom_range(0, 3));
        3: a = Base + 32'd4096;
        default: a = Base + 32'($urandom_range(0, 63));
      endcase
      xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
           $urandom_range(0, 2), lat, rd, er);
    end

    for (int i = 0; i < 20; i++) chk("final_mem", dmem[i], ref_mem[i]);
    chk("final_mem_top", dmem[1023], ref_mem[1023]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_err);
    $fatal(1);
  end
endmodule
